// File: rtl/rtlram_arbfwd_lat.sv
// Engine read/write + CPU port arbiter onto a 1R1W RAM: RDLAT-stage read pipeline with write forwarding, starvation-forced CPU grants.
// Reads return RDLAT clocks after grant (uprdy one later); engine backpressured one cycle on force. Optional fwdhit counter: RTLRAM_FWDCNT_EN.
module rtlram_arbfwd_lat #(
   parameter int ADDRBIT = 5,
   parameter int WIDTH   = 32,
   parameter int RDLAT   = 2,
   parameter int MAXWAIT = 15
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               active,
   input  logic               eng_re,
   input  logic [ADDRBIT-1:0] eng_ra,
   output logic               eng_rrdy,
   output logic               eng_rvld,
   output logic [WIDTH-1:0]   eng_rdd,
   input  logic               eng_we,
   input  logic [ADDRBIT-1:0] eng_wa,
   input  logic [WIDTH-1:0]   eng_wrd,
   output logic               eng_wrdy,
   input  logic               upen,
   input  logic [ADDRBIT-1:0] upa,
   input  logic               upws,
   input  logic               uprs,
   input  logic [WIDTH-1:0]   updi,
   output logic [WIDTH-1:0]   updo,
   output logic               uprdy,
   output logic               memwe,
   output logic [ADDRBIT-1:0] memwa,
   output logic [WIDTH-1:0]   memwrd,
   output logic               memre,
   output logic [ADDRBIT-1:0] memra,
   input  logic [WIDTH-1:0]   memrdd
`ifdef RTLRAM_FWDCNT_EN
   ,
   output logic [15:0]        fwdhit
`endif
);

   localparam int LAST = RDLAT - 1;

   logic               engrd, engwr, eng_racc, eng_wacc;
   logic               wr_pend, rd_pend, wf, rf, cgw, cgr, rd_grant;
   logic [7:0]         wcnt, rcnt;
   logic [RDLAT-1:0]   p_v, p_cpu, p_ff, c_sr, hit;
   logic [ADDRBIT-1:0] p_a [RDLAT];
   logic [WIDTH-1:0]   p_d [RDLAT];
   logic [WIDTH-1:0]   pipe_out, eng_hold, updo_q;

   always_comb begin
      engrd    = eng_re & active;
      engwr    = eng_we & active;
      wf       = wr_pend & (wcnt == 8'(MAXWAIT));
      rf       = rd_pend & (rcnt == 8'(MAXWAIT));
      eng_wrdy = ~wf;
      eng_rrdy = ~rf;
      // CPU write also wins a same-address collision; the engine write is then dropped.
      cgw      = wr_pend & (wf | ~engwr | (eng_wa == upa));
      eng_wacc = engwr & eng_wrdy;
      memwe    = cgw | eng_wacc;
      memwa    = cgw ? upa  : eng_wa;
      memwrd   = cgw ? updi : eng_wrd;
      eng_racc = engrd & eng_rrdy;
      cgr      = rd_pend & (rf | ~engrd);
      rd_grant = eng_racc | cgr;
      memra    = eng_racc ? eng_ra : upa;
      memre    = rd_grant & ~(memwe & (memwa == memra));
      // hit[0]: write in the read's own issue cycle; hit[i]: write while the read sits in stage i-1.
      hit      = '0;
      hit[0]   = rd_grant & memwe & (memwa == memra);
      for (int i = 1; i < RDLAT; i++)
         hit[i] = p_v[i-1] & memwe & (memwa == p_a[i-1]);
      pipe_out = p_ff[LAST] ? p_d[LAST] : memrdd;
      eng_rvld = p_v[LAST] & ~p_cpu[LAST];
      eng_rdd  = eng_rvld ? pipe_out : eng_hold;
      updo     = upen ? updo_q : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_pend <= 1'b0;
         rd_pend <= 1'b0;
         wcnt    <= '0;
         rcnt    <= '0;
      end else if (!upen) begin
         wr_pend <= 1'b0;
         rd_pend <= 1'b0;
         wcnt    <= '0;
         rcnt    <= '0;
      end else begin
         wr_pend <= upws | (wr_pend & ~cgw);
         rd_pend <= uprs | (rd_pend & ~cgr);
         if (cgw)
            wcnt <= '0;
         else if (wr_pend && wcnt != 8'hFF)
            wcnt <= wcnt + 8'd1;
         if (cgr)
            rcnt <= '0;
         else if (rd_pend && rcnt != 8'hFF)
            rcnt <= rcnt + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p_v      <= '0;
         p_cpu    <= '0;
         p_ff     <= '0;
         c_sr     <= '0;
         for (int i = 0; i < RDLAT; i++) begin
            p_a[i] <= '0;
            p_d[i] <= '0;
         end
         eng_hold <= '0;
         updo_q   <= '0;
         uprdy    <= 1'b0;
      end else begin
         p_v[0]   <= rd_grant;
         p_cpu[0] <= cgr;
         p_a[0]   <= memra;
         p_ff[0]  <= hit[0];
         p_d[0]   <= memwrd;
         c_sr[0]  <= cgw | cgr;
         for (int i = 1; i < RDLAT; i++) begin
            p_v[i]   <= p_v[i-1];
            p_cpu[i] <= p_cpu[i-1];
            p_a[i]   <= p_a[i-1];
            p_ff[i]  <= p_ff[i-1] | hit[i];
            p_d[i]   <= hit[i] ? memwrd : p_d[i-1];
            c_sr[i]  <= c_sr[i-1];
         end
         uprdy <= upen & c_sr[LAST];
         if (eng_rvld)
            eng_hold <= pipe_out;
         if (p_v[LAST] & p_cpu[LAST])
            updo_q <= pipe_out;
      end
   end

`ifdef RTLRAM_FWDCNT_EN
   logic [15:0] fwd_inc;

   always_comb begin
      fwd_inc = 16'(cgw & eng_wacc);
      for (int i = 0; i < RDLAT; i++)
         fwd_inc = fwd_inc + 16'(hit[i]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         fwdhit <= '0;
      else if (cgr && (upa == '1))
         fwdhit <= '0;
      else if (fwdhit > (16'hFFFF - fwd_inc))
         fwdhit <= 16'hFFFF;
      else
         fwdhit <= fwdhit + fwd_inc;
   end
`endif

endmodule

// File: tb/tb_rtlram_arbfwd_lat.sv
// Directed bench for rtlram_arbfwd_lat (RDLAT=2, MAXWAIT=15) with a behavioural RAM model.
module tb_rtlram_arbfwd_lat;
   localparam int AW = 5;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          active, eng_re, eng_we, upen, upws, uprs;
   logic [AW-1:0] eng_ra, eng_wa, upa;
   logic [DW-1:0] eng_wrd, updi;
   logic          eng_rrdy, eng_rvld, eng_wrdy, uprdy, memwe, memre;
   logic [DW-1:0] eng_rdd, updo, memwrd;
   logic [DW-1:0] memrdd;
   logic [AW-1:0] memwa, memra;

   always #5 clk = ~clk;

   rtlram_arbfwd_lat #(.ADDRBIT(AW), .WIDTH(DW), .RDLAT(2), .MAXWAIT(15)) dut (
      .clk(clk), .rst(rst), .active(active),
      .eng_re(eng_re), .eng_ra(eng_ra), .eng_rrdy(eng_rrdy), .eng_rvld(eng_rvld), .eng_rdd(eng_rdd),
      .eng_we(eng_we), .eng_wa(eng_wa), .eng_wrd(eng_wrd), .eng_wrdy(eng_wrdy),
      .upen(upen), .upa(upa), .upws(upws), .uprs(uprs), .updi(updi), .updo(updo), .uprdy(uprdy),
      .memwe(memwe), .memwa(memwa), .memwrd(memwrd), .memre(memre), .memra(memra), .memrdd(memrdd)
   );

   // RAM with two-clock read latency; a cycle without memre returns a poison word.
   logic [DW-1:0] mem [32];
   logic [DW-1:0] rd1;
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) mem[i] <= 32'h100 + 32'(i);
         mem[3] <= 32'hA5;
      end else if (memwe) begin
         mem[memwa] <= memwrd;
      end
      rd1    <= memre ? mem[memra] : 32'hBAD0BAD0;
      memrdd <= rd1;
   end

   typedef struct packed {
      logic rrdy, wrdy, rvld;
      logic [31:0] rdd;
      logic mwe, mre, urdy;
      logic [31:0] updo;
   } exp_t;

   typedef struct {
      logic act, ere;
      logic [4:0] era;
      logic ewe;
      logic [4:0] ewa;
      logic [31:0] ewd;
      logic upen;
      logic [4:0] upa;
      logic ws, rs;
      logic [31:0] updi;
      exp_t x;
   } vec_t;

   int nchk, nerr;
   vec_t vt [20];

   function automatic exp_t xp(input int rr, wr, rv, input logic [31:0] rd,
                               input int mw, mr, ur, input logic [31:0] ud);
      xp = '{1'(rr), 1'(wr), 1'(rv), rd, 1'(mw), 1'(mr), 1'(ur), ud};
   endfunction

   function automatic vec_t mkv(input int act, ere, era, ewe, ewa, input logic [31:0] ewd,
                                input int un, ua, ws, rs, input logic [31:0] ud, input exp_t x);
      mkv = '{1'(act), 1'(ere), 5'(era), 1'(ewe), 5'(ewa), ewd, 1'(un), 5'(ua), 1'(ws), 1'(rs), ud, x};
   endfunction

   task automatic apply(input vec_t v);
      active = v.act; eng_re = v.ere; eng_ra = v.era;
      eng_we = v.ewe; eng_wa = v.ewa; eng_wrd = v.ewd;
      upen = v.upen; upa = v.upa; upws = v.ws; uprs = v.rs; updi = v.updi;
   endtask

   task automatic idle_in();
      active = 1'b1; eng_re = 1'b0; eng_ra = '0; eng_we = 1'b0; eng_wa = '0; eng_wrd = '0;
      upen = 1'b0; upa = '0; upws = 1'b0; uprs = 1'b0; updi = '0;
   endtask

   task automatic check_outs(input string nm, input exp_t x);
      exp_t a;
      a = '{eng_rrdy, eng_wrdy, eng_rvld, eng_rdd, memwe, memre, uprdy, updo};
      nchk++;
      if (a !== x) begin
         nerr++;
         $display("FAIL %s: got rrdy=%b wrdy=%b rvld=%b rdd=%h we=%b re=%b uprdy=%b updo=%h; want rrdy=%b wrdy=%b rvld=%b rdd=%h we=%b re=%b uprdy=%b updo=%h",
                  nm, a.rrdy, a.wrdy, a.rvld, a.rdd, a.mwe, a.mre, a.urdy, a.updo,
                  x.rrdy, x.wrdy, x.rvld, x.rdd, x.mwe, x.mre, x.urdy, x.updo);
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h want %h", nm, got, exp);
      end
   endtask

   // Engine hammers one port while a CPU access waits; the force must fire on the 16th cycle.
   task automatic starve(input bit wr);
      int low_n, low_at, rdy_n, rdy_at, rv_n, bad;
      logic [31:0] updo_at;
      low_n = 0; low_at = -1; rdy_n = 0; rdy_at = -1; rv_n = 0; bad = 0; updo_at = '0;
      idle_in();
      upen = 1'b1;
      if (wr) begin
         eng_we = 1'b1; eng_wa = 5'd1; eng_wrd = 32'h99;
         upa = 5'd2; upws = 1'b1; updi = 32'hC3;
      end else begin
         eng_re = 1'b1; eng_ra = 5'd5;
         upa = 5'd3; uprs = 1'b1;
      end
      for (int s = 0; s < 24; s++) begin
         @(negedge clk);
         if ((wr ? eng_wrdy : eng_rrdy) == 1'b0) begin low_n++; low_at = s; end
         if (uprdy) begin rdy_n++; rdy_at = s; updo_at = updo; end
         if (eng_rvld) begin
            rv_n++;
            if (eng_rdd !== 32'h105) bad++;
         end
         @(posedge clk); #1;
         upws = 1'b0; uprs = 1'b0;
      end
      idle_in();
      repeat (4) @(posedge clk);
      #1;
      chk(wr ? "wstarve_low_cycles" : "rstarve_low_cycles", 32'(low_n), 32'd1);
      chk(wr ? "wstarve_low_at" : "rstarve_low_at", 32'(low_at), 32'd16);
      chk(wr ? "wstarve_uprdy_n" : "rstarve_uprdy_n", 32'(rdy_n), 32'd1);
      chk(wr ? "wstarve_uprdy_at" : "rstarve_uprdy_at", 32'(rdy_at), 32'd19);
      if (wr) begin
         chk("wstarve_mem2", mem[2], 32'hC3);
         chk("wstarve_mem1", mem[1], 32'h99);
      end else begin
         chk("rstarve_updo", updo_at, 32'hA5);
         chk("rstarve_rvld_n", 32'(rv_n), 32'd21);
         chk("rstarve_rdd_bad", 32'(bad), 32'd0);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int rv_n;
      nchk = 0; nerr = 0;
      rst = 1'b1;
      idle_in();
      active = 1'b0;

      //          act ere era ewe ewa ewd    upen upa ws rs updi   rrdy wrdy rvld rdd  we re urdy updo
      vt[0]  = mkv(1, 1, 3, 0, 0, 0,     0, 0, 0, 0, 0,    xp(1, 1, 0, 0,    0, 1, 0, 0));
      vt[1]  = mkv(1, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0,    xp(1, 1, 0, 0,    0, 0, 0, 0));
      vt[2]  = mkv(1, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0,    xp(1, 1, 1, 'hA5, 0, 0, 0, 0));
      vt[3]  = mkv(1, 1, 4, 0, 0, 0,     0, 0, 0, 0, 0,    xp(1, 1, 0, 'hA5, 0, 1, 0, 0));
      vt[4]  = mkv(1, 0, 0, 1, 4, 'h11,  0, 0, 0, 0, 0,    xp(1, 1, 0, 'hA5, 1, 0, 0, 0));
      vt[5]  = mkv(1, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0,    xp(1, 1, 1, 'h11, 0, 0, 0, 0));
      vt[6]  = mkv(1, 1, 9, 1, 9, 'h77,  0, 0, 0, 0, 0,    xp(1, 1, 0, 'h11, 1, 0, 0, 0));
      vt[7]  = mkv(1, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0,    xp(1, 1, 0, 'h11, 0, 0, 0, 0));
      vt[8]  = mkv(1, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0,    xp(1, 1, 1, 'h77, 0, 0, 0, 0));
      vt[9]  = mkv(1, 0, 0, 0, 0, 0,     1, 7, 1, 0, 'h55, xp(1, 1, 0, 'h77, 0, 0, 0, 0));
      vt[10] = mkv(1, 0, 0, 1, 7, 'h22,  1, 7, 0, 0, 'h55, xp(1, 1, 0, 'h77, 1, 0, 0, 0));
      vt[11] = mkv(1, 0, 0, 0, 0, 0,     1, 7, 0, 0, 'h55, xp(1, 1, 0, 'h77, 0, 0, 0, 0));
      vt[12] = mkv(1, 0, 0, 0, 0, 0,     1, 7, 0, 0, 'h55, xp(1, 1, 0, 'h77, 0, 0, 0, 0));
      vt[13] = mkv(1, 0, 0, 0, 0, 0,     1, 7, 0, 0, 'h55, xp(1, 1, 0, 'h77, 0, 0, 1, 0));
      vt[14] = mkv(1, 0, 0, 0, 0, 0,     1, 7, 0, 1, 0,    xp(1, 1, 0, 'h77, 0, 0, 0, 0));
      vt[15] = mkv(1, 0, 0, 0, 0, 0,     1, 7, 0, 0, 0,    xp(1, 1, 0, 'h77, 0, 1, 0, 0));
      vt[16] = mkv(1, 0, 0, 0, 0, 0,     1, 7, 0, 0, 0,    xp(1, 1, 0, 'h77, 0, 0, 0, 0));
      vt[17] = mkv(1, 0, 0, 0, 0, 0,     1, 7, 0, 0, 0,    xp(1, 1, 0, 'h77, 0, 0, 0, 0));
      vt[18] = mkv(1, 0, 0, 0, 0, 0,     1, 7, 0, 0, 0,    xp(1, 1, 0, 'h77, 0, 0, 1, 'h55));
      vt[19] = mkv(1, 0, 0, 0, 0, 0,     0, 7, 0, 0, 0,    xp(1, 1, 0, 'h77, 0, 0, 0, 0));

      repeat (2) @(posedge clk);
      @(negedge clk);
      check_outs("reset_state", xp(1, 1, 0, 0, 0, 0, 0, 0));
      @(posedge clk); #1;
      rst = 1'b0;

      for (int k = 0; k < 20; k++) begin
         apply(vt[k]);
         @(negedge clk);
         check_outs($sformatf("row%0d", k), vt[k].x);
         @(posedge clk); #1;
      end
      chk("mem4_after_fwd", mem[4], 32'h11);
      chk("mem9_same_cycle", mem[9], 32'h77);
      chk("mem7_collision", mem[7], 32'h55);

      starve(1'b0);
      starve(1'b1);

      // Reset with two engine reads in flight.
      idle_in();
      eng_re = 1'b1; eng_ra = 5'd3;
      @(posedge clk); #1;
      eng_ra = 5'd4;
      @(posedge clk); #1;
      eng_re = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check_outs("reset_midflight", xp(1, 1, 0, 0, 0, 0, 0, 0));
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      rv_n = 0;
      @(negedge clk);
      chk("post_reset_rdy", {30'd0, eng_rrdy, eng_wrdy}, 32'd3);
      for (int s = 0; s < 5; s++) begin
         if (eng_rvld || uprdy) rv_n++;
         @(negedge clk);
      end
      chk("post_reset_no_rvld", 32'(rv_n), 32'd0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
